alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Lets two requesters share one external combinational ALU. A three-state
//   FSM (IDLE -> EXEC -> RESP) grants one request, registers its operands
//   toward the ALU, captures the ALU result one cycle later, and then holds
//   the response until the consumer accepts it. The block performs no
//   arithmetic of its own; results pass through unmodified.
//
// Configuration:
//   ALU_ARB_RR_EN  defined   -> round-robin arbitration with a 1-bit pointer
//                  undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           operation requests, held until granted
//   a0,b0,ctl0          requester 0 operands and ALU control code
//   a1,b1,ctl1          requester 1 operands and ALU control code
//   gnt0/gnt1           combinational one-cycle acceptance pulses
//   alu_a,alu_b,alu_ctl registered operands/control to the shared ALU
//   alu_result,alu_zero combinational result and zero flag from the ALU
//   rsp_valid,rsp_id    response available / owning requester
//   rsp_result,rsp_zero captured ALU result and zero flag
//   rsp_ready           consumer accepts the response with rsp_valid
//   busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTLW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [CTLW-1:0]  ctl0,
  input  logic [CTLW-1:0]  ctl1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTLW-1:0]  alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic pick0;
  logic pick1;
  logic grantEn;
  logic grantAny;

  logic [WIDTH-1:0] aluA_q, aluB_q;
  logic [CTLW-1:0]  aluCtl_q;
  logic             rspId_q;
  logic [WIDTH-1:0] rspResult_q;
  logic             rspZero_q;

`ifdef ALU_ARB_RR_EN
  // Round-robin winner selection. prio_q names the requester that is
  // favoured on the next tie; it is the complement of the last granted
  // requester, so reset (prio_q = 0) favours requester 0 and every tie
  // afterwards alternates.
  logic prio_q, prio_d;

  always_comb begin
    pick0 = req0 & (~req1 | ~prio_q);
    pick1 = req1 & (~req0 |  prio_q);
  end

  // After any grant the other requester becomes favoured.
  always_comb begin
    prio_d = prio_q;
    if (grantAny) begin
      prio_d = gnt0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Fixed priority: requester 0 always beats requester 1, so no pointer
  // state is kept at all.
  always_comb begin
    pick0 = req0;
    pick1 = ~req0 & req1;
  end
`endif

  // Grants may only be issued from IDLE and never while reset is applied;
  // the pick signals are already mutually exclusive, so at most one gnt
  // can be high.
  always_comb begin
    grantEn  = (state_q == IDLE) && !rst;
    gnt0     = grantEn & pick0;
    gnt1     = grantEn & pick1;
    grantAny = gnt0 | gnt1;
  end

  // Next-state logic. A granted request moves to EXEC, EXEC always lasts
  // exactly one cycle while the ALU settles on the registered operands, and
  // RESP waits for the consumer handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grantAny) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath capture. Operands and owner id are loaded on the grant edge;
  // the ALU result is sampled at the end of EXEC, when it reflects the
  // registered operands. Reset wipes any in-flight or pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluCtl_q    <= '0;
      rspId_q     <= 1'b0;
      rspResult_q <= '0;
      rspZero_q   <= 1'b0;
    end else begin
      if (grantAny) begin
        aluA_q   <= gnt1 ? a1 : a0;
        aluB_q   <= gnt1 ? b1 : b0;
        aluCtl_q <= gnt1 ? ctl1 : ctl0;
        rspId_q  <= gnt1;
      end
      if (state_q == EXEC) begin
        rspResult_q <= alu_result;
        rspZero_q   <= alu_zero;
      end
    end
  end

  // Output mapping; response valid and busy come straight from the state.
  always_comb begin
    alu_a      = aluA_q;
    alu_b      = aluB_q;
    alu_ctl    = aluCtl_q;
    rsp_id     = rspId_q;
    rsp_result = rspResult_q;
    rsp_zero   = rspZero_q;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural ALU model drives the
// DUT's ALU result inputs; expected grants and responses come from a
// transaction-level reference model (winner rule plus ALU function applied
// to the requester's own operands). Honours ALU_ARB_RR_EN for the expected
// arbitration order.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int CTLW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [CTLW-1:0]  ctl0, ctl1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] aluA, aluB;
  logic [CTLW-1:0]  aluCtl;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;
  logic             rspValid;
  logic             rspId;
  logic [WIDTH-1:0] rspResult;
  logic             rspZero;
  logic             rspReady;
  logic             busy;

  int testCount = 0;
  int failCount = 0;

  // Model state: requester favoured on the next tie (round-robin build only).
  int favoured = 0;

  logic [CTLW-1:0] ctlSet [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CTLW(CTLW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .ctl0       (ctl0),
    .ctl1       (ctl1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .alu_a      (aluA),
    .alu_b      (aluB),
    .alu_ctl    (aluCtl),
    .alu_result (aluResult),
    .alu_zero   (aluZero),
    .rsp_valid  (rspValid),
    .rsp_id     (rspId),
    .rsp_result (rspResult),
    .rsp_zero   (rspZero),
    .rsp_ready  (rspReady),
    .busy       (busy)
  );

  // Behavioural ALU: AND, OR, ADD, SUB; other codes produce zero.
  function automatic logic [WIDTH-1:0] aluModel(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [CTLW-1:0]  c);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      default: return '0;
    endcase
  endfunction

  // Shared ALU instance seen by the arbiter.
  always_comb begin
    aluResult = aluModel(aluA, aluB, aluCtl);
    aluZero   = (aluResult == '0);
  end

  // Reference arbitration rule.
  function automatic int expectedWinner(input logic r0, input logic r1);
`ifdef ALU_ARB_RR_EN
    if (r0 && r1) return favoured;
`endif
    return r0 ? 0 : 1;
  endfunction

  task automatic checkOutput(input string tag,
                             input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                               input logic [CTLW-1:0] c0,
                               input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1,
                               input logic [CTLW-1:0] c1);
    req0 = r0;
    req1 = r1;
    a0   = x0;
    b0   = y0;
    ctl0 = c0;
    a1   = x1;
    b1   = y1;
    ctl1 = c1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rsp_valid"},  rspValid,  0);
    checkOutput({tag, "_rsp_id"},     rspId,     0);
    checkOutput({tag, "_rsp_result"}, rspResult, 0);
    checkOutput({tag, "_rsp_zero"},   rspZero,   0);
    checkOutput({tag, "_alu_a"},      aluA,      0);
    checkOutput({tag, "_alu_b"},      aluB,      0);
    checkOutput({tag, "_alu_ctl"},    aluCtl,    0);
    checkOutput({tag, "_busy"},       busy,      0);
  endtask

  // One full transaction from IDLE back to IDLE. Returns the winner.
  task automatic runTxn(input logic r0, input logic r1,
                        input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                        input logic [CTLW-1:0] c0,
                        input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1,
                        input logic [CTLW-1:0] c1,
                        input int readyDelay, input bit dropWinner,
                        output int w);
    logic [WIDTH-1:0] expA, expB, expR;
    logic [CTLW-1:0]  expC;
    applyStimulus(r0, r1, x0, y0, c0, x1, y1, c1);
    rspReady = 1'b0;
    #1;
    w    = expectedWinner(r0, r1);
    expA = (w == 0) ? x0 : x1;
    expB = (w == 0) ? y0 : y1;
    expC = (w == 0) ? c0 : c1;
    expR = aluModel(expA, expB, expC);
    checkOutput("idle_gnt0", gnt0, (w == 0));
    checkOutput("idle_gnt1", gnt1, (w == 1));
    checkOutput("idle_busy", busy, 0);
    favoured = 1 - w;

    // Grant edge N: operands now registered, FSM in EXEC.
    stepClk();
    if (dropWinner) begin
      if (w == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end
    #1;
    checkOutput("exec_alu_a",     aluA,     expA);
    checkOutput("exec_alu_b",     aluB,     expB);
    checkOutput("exec_alu_ctl",   aluCtl,   expC);
    checkOutput("exec_busy",      busy,     1);
    checkOutput("exec_rsp_valid", rspValid, 0);
    checkOutput("exec_gnt0",      gnt0,     0);
    checkOutput("exec_gnt1",      gnt1,     0);

    // Edge N+1: response visible, first sampled high at edge N+2.
    stepClk();
    checkOutput("resp_valid",  rspValid,  1);
    checkOutput("resp_id",     rspId,     w);
    checkOutput("resp_result", rspResult, expR);
    checkOutput("resp_zero",   rspZero,   (expR == '0));
    checkOutput("resp_gnt",    gnt0 | gnt1, 0);

    for (int i = 0; i < readyDelay; i++) begin
      stepClk();
      checkOutput("hold_valid",  rspValid,  1);
      checkOutput("hold_id",     rspId,     w);
      checkOutput("hold_result", rspResult, expR);
    end

    rspReady = 1'b1;
    stepClk();
    rspReady = 1'b0;
    checkOutput("done_busy",  busy,     0);
    checkOutput("done_valid", rspValid, 0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);
    rspReady = 1'b0;
    stepClk();
    stepClk();
    rst = 1'b0;
    favoured = 0;
  endtask

  initial begin
    int w;
    bit pend0, pend1;
    logic r0, r1;
    logic [WIDTH-1:0] x0, y0, x1, y1;
    logic [CTLW-1:0]  c0, c1;

    // Reset with requests present: no grants allowed during reset.
    rst = 1'b1;
    rspReady = 1'b0;
    applyStimulus(1, 1, 32'd3, 32'd4, 4'b0010, 32'd5, 32'd6, 4'b0010);
    stepClk();
    stepClk();
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_gnt1", gnt1, 0);
    checkResetValues("rst");
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);
    rst = 1'b0;
    favoured = 0;

    // Basic directed transactions; the first one grants right after reset.
    runTxn(1, 0, 32'd11, 32'd12, 4'b0000, 32'd0, 32'd0, 4'b0000, 0, 1, w);
    runTxn(0, 1, 32'd0, 32'd0, 4'b0000, 32'd11, 32'd12, 4'b0010, 4, 1, w);
    runTxn(1, 0, 32'd5, 32'd5, 4'b0110, 32'd0, 32'd0, 4'b0000, 1, 1, w);

    // Both requesters held high continuously.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      runTxn(1, 1, 32'd100 + i, 32'd7, 4'b0010, 32'd200 + i, 32'd9, 4'b0110, 0, 0, w);
`ifdef ALU_ARB_RR_EN
      checkOutput("rr_order", w, i % 2);
`else
      checkOutput("fixed_order", w, 0);
`endif
    end
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);

    // Randomized traffic; a losing requester keeps its request and operands.
    pend0 = 0;
    pend1 = 0;
    x0 = '0; y0 = '0; c0 = '0; x1 = '0; y1 = '0; c1 = '0;
    for (int t = 0; t < 24; t++) begin
      r0 = pend0 | $urandom_range(0, 1);
      r1 = pend1 | $urandom_range(0, 1);
      if (!r0 && !r1) r1 = 1'b1;
      if (!pend0) begin
        x0 = $urandom;
        y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
        c0 = ctlSet[$urandom_range(0, 3)];
      end
      if (!pend1) begin
        x1 = $urandom;
        y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
        c1 = ctlSet[$urandom_range(0, 3)];
      end
      runTxn(r0, r1, x0, y0, c0, x1, y1, c1, $urandom_range(0, 2), 1, w);
      pend0 = r0 && (w != 0);
      pend1 = r1 && (w != 1);
    end
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);

    // Reset during EXEC aborts the operation.
    resetDut();
    applyStimulus(0, 1, '0, '0, '0, 32'd40, 32'd2, 4'b0010);
    #1;
    checkOutput("abort_exec_gnt1", gnt1, 1);
    stepClk();
    req1 = 1'b0;
    rst  = 1'b1;
    stepClk();
    rst  = 1'b0;
    checkResetValues("abort_exec");
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("abort_exec_no_rsp", rspValid, 0);
    end

    // Reset during RESP discards the pending response.
    favoured = 0;
    applyStimulus(1, 0, 32'd9, 32'd3, 4'b0001, '0, '0, '0);
    #1;
    checkOutput("abort_resp_gnt0", gnt0, 1);
    stepClk();
    req0 = 1'b0;
    stepClk();
    checkOutput("abort_resp_valid_pre", rspValid, 1);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkResetValues("abort_resp");
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("abort_resp_no_rsp", rspValid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
